mem_arb: RTL and testbench

- Two-master arbiter and sequencer in front of the single-port word RAM.
- The RAM side uses the ram_wr_req/ram_wr_ack, ram_rd_req/ram_rd_ack, ram_addr, ram_wdata and ram_rdata interface.
- Masters are a PSRAM host-side engine and a DMA/test engine. Each master sees a simple req/ack port with a read-data return pulse.
- The block serialises accesses, holds RAM strobes until acked, and routes read data back to the granted master.

---
 rtl/mem_arb.sv | 114 +++++++++++
 tb/tb_mem_arb.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-master arbiter and sequencer in front of a single-port word RAM.
// Serialises accesses, holds RAM strobes until acked, routes read data back to the granted master.
module mem_arb #(
   parameter int unsigned AW       = 17,
   parameter int unsigned DW       = 32,
   parameter int unsigned ARB_MODE = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_rvalid,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_rvalid,
   output logic          ram_wr_req,
   input  logic          ram_wr_ack,
   output logic          ram_rd_req,
   input  logic          ram_rd_ack,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   typedef enum logic [1:0] {IDLE, CMD, RDATA} state_t;

   state_t state;
   logic   last_grant;
   logic   gnt;
   logic   we_q;
   logic   win_c;
   logic   win_we_c;

   // Winner selection; only meaningful when at least one master requests.
   always_comb begin
      win_c = 1'b0;
      if (ARB_MODE == 1) begin
         win_c = !m0_req;
      end else if (m0_req && m1_req) begin
         win_c = !last_grant;
      end else begin
         win_c = !m0_req;
      end
      win_we_c = win_c ? m1_we : m0_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         we_q       <= 1'b0;
         m0_ack     <= 1'b0;
         m0_rdata   <= '0;
         m0_rvalid  <= 1'b0;
         m1_ack     <= 1'b0;
         m1_rdata   <= '0;
         m1_rvalid  <= 1'b0;
         ram_wr_req <= 1'b0;
         ram_rd_req <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
      end else begin
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  ram_addr   <= win_c ? m1_addr  : m0_addr;
                  ram_wdata  <= win_c ? m1_wdata : m0_wdata;
                  ram_wr_req <= win_we_c;
                  ram_rd_req <= !win_we_c;
                  m0_ack     <= !win_c;
                  m1_ack     <= win_c;
                  last_grant <= win_c;
                  gnt        <= win_c;
                  we_q       <= win_we_c;
                  state      <= CMD;
               end
            end
            CMD: begin
               // Strobe, address and data stay put until the matching ack.
               if (we_q ? ram_wr_ack : ram_rd_ack) begin
                  ram_wr_req <= 1'b0;
                  ram_rd_req <= 1'b0;
                  state      <= we_q ? IDLE : RDATA;
               end
            end
            RDATA: begin
               if (gnt) begin
                  m1_rdata  <= ram_rdata;
                  m1_rvalid <= 1'b1;
               end else begin
                  m0_rdata  <= ram_rdata;
                  m0_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: round-robin instance with a RAM model, plus a
// fixed-priority instance with a zero-wait stub for the priority scenario.
module tb_mem_arb;
   localparam int unsigned AW = 17;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;

   logic          d0_m0_ack, d0_m0_rvalid, d0_m1_ack, d0_m1_rvalid;
   logic [DW-1:0] d0_m0_rdata, d0_m1_rdata;
   logic          ram_wr_req, ram_wr_ack, ram_rd_req, ram_rd_ack;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_rdata;

   logic          d1_m0_ack, d1_m0_rvalid, d1_m1_ack, d1_m1_rvalid;
   logic [DW-1:0] d1_m0_rdata, d1_m1_rdata;
   logic          d1_ram_wr_req, d1_ram_wr_ack, d1_ram_rd_req, d1_ram_rd_ack;
   logic [AW-1:0] d1_ram_addr;
   logic [DW-1:0] d1_ram_wdata, d1_ram_rdata;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   mem_arb #(.AW(AW), .DW(DW), .ARB_MODE(0)) dut0 (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(d0_m0_ack), .m0_rdata(d0_m0_rdata), .m0_rvalid(d0_m0_rvalid),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(d0_m1_ack), .m1_rdata(d0_m1_rdata), .m1_rvalid(d0_m1_rvalid),
      .ram_wr_req(ram_wr_req), .ram_wr_ack(ram_wr_ack),
      .ram_rd_req(ram_rd_req), .ram_rd_ack(ram_rd_ack),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   mem_arb #(.AW(AW), .DW(DW), .ARB_MODE(1)) dut1 (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(d1_m0_ack), .m0_rdata(d1_m0_rdata), .m0_rvalid(d1_m0_rvalid),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(d1_m1_ack), .m1_rdata(d1_m1_rdata), .m1_rvalid(d1_m1_rvalid),
      .ram_wr_req(d1_ram_wr_req), .ram_wr_ack(d1_ram_wr_ack),
      .ram_rd_req(d1_ram_rd_req), .ram_rd_ack(d1_ram_rd_ack),
      .ram_addr(d1_ram_addr), .ram_wdata(d1_ram_wdata), .ram_rdata(d1_ram_rdata)
   );

   assign d1_ram_wr_ack = d1_ram_wr_req;
   assign d1_ram_rd_ack = d1_ram_rd_req;
   assign d1_ram_rdata  = '0;

   // RAM model: combinational write ack, read ack after rd_delay wait cycles, registered rdata.
   logic [DW-1:0] mem [0:(2**AW)-1];
   int            rd_delay = 0;
   int            wait_cnt = 0;
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   assign ram_wr_ack = ram_wr_req;
   assign ram_rd_ack = ram_rd_req && (wait_cnt >= rd_delay);

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (ram_wr_req && ram_wr_ack) mem[ram_addr] <= ram_wdata;
      if (ram_rd_req && ram_rd_ack) ram_rdata <= mem[ram_addr];
      wait_cnt <= (ram_rd_req && !ram_rd_ack) ? wait_cnt + 1 : 0;
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      step();
      pl_en = 1'b0;
   endtask

   // Issues one m0 read and waits (bounded) for its rvalid; lat = cycles until rvalid, -1 on timeout.
   task automatic m0_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = a;
      lat = -1; d = '0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (d0_m0_ack) m0_req = 1'b0;
         if (d0_m0_rvalid) begin
            d = d0_m0_rdata; lat = k;
            break;
         end
      end
      m0_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
      m0_we = 1'b0; m1_we = 1'b0; m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
      step(); step();
      checks++;
      if ({d0_m0_ack, d0_m1_ack, d0_m0_rvalid, d0_m1_rvalid, ram_wr_req, ram_rd_req} !== 6'b0) begin
         failures++;
         $display("FAIL reset_strobes got=%b expected=000000",
                  {d0_m0_ack, d0_m1_ack, d0_m0_rvalid, d0_m1_rvalid, ram_wr_req, ram_rd_req});
      end
      checks++;
      if (ram_addr !== '0 || ram_wdata !== '0) begin
         failures++;
         $display("FAIL reset_ram_bus addr=%h wdata=%h expected 0", ram_addr, ram_wdata);
      end
      checks++;
      if (d0_m0_rdata !== '0 || d0_m1_rdata !== '0) begin
         failures++;
         $display("FAIL reset_rdata m0=%h m1=%h expected 0", d0_m0_rdata, d0_m1_rdata);
      end
      checks++;
      if ({d1_m0_ack, d1_m1_ack, d1_ram_wr_req, d1_ram_rd_req} !== 4'b0) begin
         failures++;
         $display("FAIL reset_prio_inst got=%b expected=0000",
                  {d1_m0_ack, d1_m1_ack, d1_ram_wr_req, d1_ram_rd_req});
      end
      rst = 1'b0;
   endtask

   task automatic test_single_write_read();
      logic [DW-1:0] d;
      int lat;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = AW'(32'h10); m0_wdata = 32'hDEADBEEF;
      step();
      checks++;
      if (d0_m0_ack !== 1'b1 || d0_m1_ack !== 1'b0) begin
         failures++;
         $display("FAIL single_wr_ack m0_ack=%b m1_ack=%b expected 1/0", d0_m0_ack, d0_m1_ack);
      end
      checks++;
      if (ram_wr_req !== 1'b1 || ram_rd_req !== 1'b0 || ram_addr !== AW'(32'h10) || ram_wdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL single_wr_cmd wr=%b rd=%b addr=%h wdata=%h expected 1 0 00010 deadbeef",
                  ram_wr_req, ram_rd_req, ram_addr, ram_wdata);
      end
      m0_req = 1'b0;
      step();
      checks++;
      if (ram_wr_req !== 1'b0 || d0_m0_ack !== 1'b0) begin
         failures++;
         $display("FAIL single_wr_done wr=%b ack=%b expected 0 0", ram_wr_req, d0_m0_ack);
      end
      m0_read(AW'(32'h10), d, lat);
      checks++;
      if (d !== 32'hDEADBEEF || lat !== 3) begin
         failures++;
         $display("FAIL single_rd data=%h lat=%0d expected deadbeef 3", d, lat);
      end
      step();
      checks++;
      if (d0_m0_rvalid !== 1'b0 || d0_m0_rdata !== 32'hDEADBEEF || d0_m1_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL single_rd_hold rvalid=%b rdata=%h m1_rvalid=%b expected 0 deadbeef 0",
                  d0_m0_rvalid, d0_m0_rdata, d0_m1_rvalid);
      end
   endtask

   task automatic test_round_robin();
      int grant [0:15];
      int n0 = 0, n1 = 0, ng = 0, rv = 0;
      logic [DW-1:0] expq [$];
      logic [DW-1:0] e;
      for (int i = 0; i < 4; i++) preload(AW'(32'h2000 + i), 32'hA500_0000 | DW'(i));
      do_reset();
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = AW'(32'h1000); m0_wdata = 32'h5000_0000;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = AW'(32'h2000);
      for (int k = 0; k < 80 && (n0 < 4 || n1 < 4 || rv < 4); k++) begin
         step();
         checks++;
         if ((d0_m0_ack & d0_m1_ack) !== 1'b0) begin
            failures++;
            $display("FAIL rr_double_ack cycle=%0d m0=%b m1=%b expected one-hot", k, d0_m0_ack, d0_m1_ack);
         end
         if (d0_m0_ack) begin
            if (ng < 16) grant[ng] = 0;
            ng++; n0++;
            if (n0 >= 4) m0_req = 1'b0;
            else begin
               m0_addr = AW'(32'h1000 + n0); m0_wdata = 32'h5000_0000 | DW'(n0);
            end
         end
         if (d0_m1_ack) begin
            if (ng < 16) grant[ng] = 1;
            ng++;
            expq.push_back(32'hA500_0000 | DW'(n1));
            n1++;
            if (n1 >= 4) m1_req = 1'b0;
            else m1_addr = AW'(32'h2000 + n1);
         end
         if (d0_m1_rvalid) begin
            e = (expq.size() > 0) ? expq.pop_front() : 32'hXXXX_XXXX;
            rv++;
            checks++;
            if (d0_m1_rdata !== e) begin
               failures++;
               $display("FAIL rr_m1_rdata got=%h expected=%h", d0_m1_rdata, e);
            end
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      checks++;
      if (ng !== 8 || rv !== 4) begin
         failures++;
         $display("FAIL rr_counts grants=%0d rvalids=%0d expected 8 4", ng, rv);
      end
      for (int j = 0; j < 8 && j < ng; j++) begin
         checks++;
         if (grant[j] !== (j % 2)) begin
            failures++;
            $display("FAIL rr_order grant%0d got=m%0d expected=m%0d", j, grant[j], j % 2);
         end
      end
   endtask

   task automatic test_fixed_priority();
      int order [0:7];
      int n0 = 0, ng = 0, last0 = -100, m1cyc = -1;
      do_reset();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = AW'(32'h3100); m1_wdata = 32'h1111;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = AW'(32'h3000); m0_wdata = 32'h2222;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (d1_m0_ack) begin
            if (ng < 8) order[ng] = 0;
            ng++; n0++; last0 = k;
            if (n0 >= 3) m0_req = 1'b0;
            else m0_addr = AW'(32'h3000 + n0);
         end
         if (d1_m1_ack) begin
            if (ng < 8) order[ng] = 1;
            ng++; m1cyc = k; m1_req = 1'b0;
            break;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      checks++;
      if (ng !== 4) begin
         failures++;
         $display("FAIL prio_count grants=%0d expected 4", ng);
      end
      for (int j = 0; j < 4 && j < ng; j++) begin
         checks++;
         if (order[j] !== ((j == 3) ? 1 : 0)) begin
            failures++;
            $display("FAIL prio_order grant%0d got=m%0d expected=m%0d", j, order[j], (j == 3) ? 1 : 0);
         end
      end
      checks++;
      if (m1cyc !== last0 + 2) begin
         failures++;
         $display("FAIL prio_m1_timing m1_ack_cycle=%0d expected=%0d", m1cyc, last0 + 2);
      end
   endtask

   task automatic test_wait_state();
      int stable = 0;
      do_reset();
      rd_delay = 3;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = AW'(32'h10);
      step();
      checks++;
      if (d0_m0_ack !== 1'b1) begin
         failures++;
         $display("FAIL ws_ack got=%b expected 1", d0_m0_ack);
      end
      m0_req = 1'b0; m0_addr = AW'(32'h1FFFF);
      for (int k = 0; k < 4; k++) begin
         if (ram_rd_req === 1'b1 && ram_wr_req === 1'b0 && ram_addr === AW'(32'h10)) stable++;
         step();
      end
      checks++;
      if (stable !== 4) begin
         failures++;
         $display("FAIL ws_stable cycles=%0d expected 4", stable);
      end
      checks++;
      if (ram_rd_req !== 1'b0 || d0_m0_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL ws_after_ack rd_req=%b rvalid=%b expected 0 0", ram_rd_req, d0_m0_rvalid);
      end
      step();
      checks++;
      if (d0_m0_rvalid !== 1'b1 || d0_m0_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL ws_rdata rvalid=%b rdata=%h expected 1 deadbeef", d0_m0_rvalid, d0_m0_rdata);
      end
      rd_delay = 0;
      step();
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = AW'(32'h10);
      step();
      m0_req = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({d0_m0_ack, d0_m1_ack, d0_m0_rvalid, d0_m1_rvalid, ram_wr_req, ram_rd_req} !== 6'b0 ||
          ram_addr !== '0 || ram_wdata !== '0 || d0_m0_rdata !== '0 || d0_m1_rdata !== '0) begin
         failures++;
         $display("FAIL rstmid_outputs flags=%b addr=%h rdata0=%h expected all 0",
                  {d0_m0_ack, d0_m1_ack, d0_m0_rvalid, d0_m1_rvalid, ram_wr_req, ram_rd_req}, ram_addr, d0_m0_rdata);
      end
      step();
      checks++;
      if (d0_m0_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_late_rvalid got=%b expected 0", d0_m0_rvalid);
      end
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = AW'(32'h10);
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = AW'(32'h50); m1_wdata = 32'h77;
      step();
      checks++;
      if (d0_m0_ack !== 1'b1 || d0_m1_ack !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_tie m0_ack=%b m1_ack=%b expected 1 0", d0_m0_ack, d0_m1_ack);
      end
      m0_req = 1'b0;
      step(); step();
      checks++;
      if (d0_m0_rvalid !== 1'b1 || d0_m0_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rstmid_next_read rvalid=%b rdata=%h expected 1 deadbeef", d0_m0_rvalid, d0_m0_rdata);
      end
      step();
      checks++;
      if (d0_m1_ack !== 1'b1 || ram_wr_req !== 1'b1 || ram_addr !== AW'(32'h50)) begin
         failures++;
         $display("FAIL rstmid_m1_next ack=%b wr=%b addr=%h expected 1 1 00050", d0_m1_ack, ram_wr_req, ram_addr);
      end
      m1_req = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      int cyc_of [0:7];
      int n = 0;
      logic [DW-1:0] d;
      int lat;
      do_reset();
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = '0; m1_wdata = '0;
      for (int k = 1; k <= 40 && n < 8; k++) begin
         step();
         if (d0_m1_ack) begin
            cyc_of[n] = k; n++;
            if (n >= 8) m1_req = 1'b0;
            else begin
               m1_addr = AW'(n); m1_wdata = DW'(n * 3);
            end
         end
      end
      m1_req = 1'b0;
      step();
      checks++;
      if (n !== 8 || cyc_of[0] !== 1) begin
         failures++;
         $display("FAIL b2b_count writes=%0d first_ack_cycle=%0d expected 8 1", n, cyc_of[0]);
      end
      for (int j = 1; j < n; j++) begin
         checks++;
         if (cyc_of[j] - cyc_of[j-1] !== 2) begin
            failures++;
            $display("FAIL b2b_spacing write%0d gap=%0d expected 2", j, cyc_of[j] - cyc_of[j-1]);
         end
      end
      for (int a = 0; a < 8; a++) begin
         m0_read(AW'(a), d, lat);
         checks++;
         if (d !== DW'(a * 3) || lat !== 3) begin
            failures++;
            $display("FAIL b2b_readback addr=%0d data=%h lat=%0d expected %h 3", a, d, lat, DW'(a * 3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write_read();
      test_round_robin();
      test_fixed_priority();
      test_wait_state();
      test_reset_mid_read();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout cycles=%0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
